// File: rtl/lbp_stream_engine.sv
// lbp_stream_engine: streaming 3x3 Local Binary Pattern engine.
// Raster-reads an IMG_W x IMG_H gray image once, keeps the two previous rows
// in line buffers plus a 3x3 window, and writes one 8-bit LBP code for every
// interior pixel.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   frame start pulse (honoured in IDLE or DONE only)
//   gray_addr/req/ready/data  gray-image read port (req/ready handshake)
//   lbp_addr/valid/data     LBP result write port (one-cycle strobe)
//   finish                  frame complete, held until start or reset
//
// Optional feature: define LBP_BORDER_WRITE_EN to add a BORDER state that
// writes code 0 to every border pixel after the interior codes.
module lbp_stream_engine #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] gray_addr,
    output logic          gray_req,
    input  logic          gray_ready,
    input  logic [DW-1:0] gray_data,
    output logic [AW-1:0] lbp_addr,
    output logic          lbp_valid,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
`ifdef LBP_BORDER_WRITE_EN
        S_BORDER,
`endif
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;

    // lb_top holds row r-2, lb_mid holds row r-1 at the column being read
    logic [DW-1:0] lb_top [IMG_W];
    logic [DW-1:0] lb_mid [IMG_W];

    // Window columns c-2 (wl_*) and c-1 (wm_*); column c arrives live
    logic [DW-1:0] wl_t, wl_m, wl_b, wm_t, wm_m, wm_b;

    logic          accept_c, last_px_c, frame_start_c, window_c;
    logic [DW-1:0] nt_c, nm_c;
    logic [7:0]    code_c;

    assign accept_c      = gray_req && gray_ready && (state_q == S_READ);
    assign last_px_c     = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign frame_start_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign window_c      = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign nt_c          = lb_top[col_q];
    assign nm_c          = lb_mid[col_q];

    // LBP code of the window centred on wm_m, completed by the incoming pixel
    always_comb begin
        code_c    = 8'h00;
        code_c[0] = (wl_t      >= wm_m);
        code_c[1] = (wm_t      >= wm_m);
        code_c[2] = (nt_c      >= wm_m);
        code_c[3] = (wl_m      >= wm_m);
        code_c[4] = (nm_c      >= wm_m);
        code_c[5] = (wl_b      >= wm_m);
        code_c[6] = (wm_b      >= wm_m);
        code_c[7] = (gray_data >= wm_m);
    end

`ifdef LBP_BORDER_WRITE_EN
    logic [RW-1:0] brow_q, brow_n_c;
    logic [CW-1:0] bcol_q, bcol_n_c;
    logic          border_last_c;

    assign border_last_c = (brow_q == RW'(IMG_H - 1)) && (bcol_q == CW'(IMG_W - 1));

    // Border walk: full first/last rows, only cols 0 and IMG_W-1 in between
    always_comb begin
        brow_n_c = brow_q;
        bcol_n_c = bcol_q;
        if ((brow_q == '0) || (brow_q == RW'(IMG_H - 1))) begin
            if (bcol_q == CW'(IMG_W - 1)) begin
                brow_n_c = brow_q + RW'(1);
                bcol_n_c = '0;
            end else begin
                bcol_n_c = bcol_q + CW'(1);
            end
        end else if (bcol_q == '0) begin
            bcol_n_c = CW'(IMG_W - 1);
        end else begin
            brow_n_c = brow_q + RW'(1);
            bcol_n_c = '0;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_READ;
            S_READ:   if (accept_c && last_px_c) state_d = S_FLUSH;
`ifdef LBP_BORDER_WRITE_EN
            S_FLUSH:  state_d = S_BORDER;
            S_BORDER: if (border_last_c) state_d = S_DONE;
`else
            S_FLUSH:  state_d = S_DONE;
`endif
            S_DONE:   if (start) state_d = S_READ;
            default:  state_d = S_IDLE;
        endcase
    end

    // Counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q     <= '0;
            col_q     <= '0;
            gray_addr <= '0;
            gray_req  <= 1'b0;
            lbp_addr  <= '0;
            lbp_valid <= 1'b0;
            lbp_data  <= 8'h00;
            finish    <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
            brow_q    <= '0;
            bcol_q    <= '0;
`endif
        end else begin
            gray_req  <= (state_d == S_READ);
            lbp_valid <= 1'b0;
            if (frame_start_c) begin
                row_q     <= '0;
                col_q     <= '0;
                gray_addr <= '0;
                finish    <= 1'b0;
            end else if (accept_c && !last_px_c) begin
                gray_addr <= gray_addr + AW'(1);
                if (col_q == CW'(IMG_W - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (accept_c && window_c) begin
                lbp_valid <= 1'b1;
                lbp_addr  <= gray_addr - AW'(IMG_W + 1);
                lbp_data  <= code_c;
            end
            if ((state_d == S_DONE) && (state_q != S_DONE)) finish <= 1'b1;
`ifdef LBP_BORDER_WRITE_EN
            if (state_q == S_FLUSH) begin
                brow_q    <= '0;
                bcol_q    <= '0;
                lbp_valid <= 1'b1;
                lbp_addr  <= '0;
                lbp_data  <= 8'h00;
            end else if ((state_q == S_BORDER) && !border_last_c) begin
                brow_q    <= brow_n_c;
                bcol_q    <= bcol_n_c;
                lbp_valid <= 1'b1;
                lbp_addr  <= AW'(32'(brow_n_c) * IMG_W + 32'(bcol_n_c));
                lbp_data  <= 8'h00;
            end
`endif
        end
    end

    // Line buffers and window shift; contents are rewritten before use
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb_top[col_q] <= nm_c;
            lb_mid[col_q] <= gray_data;
            wl_t <= wm_t;
            wl_m <= wm_m;
            wl_b <= wm_b;
            wm_t <= nt_c;
            wm_m <= nm_c;
            wm_b <= gray_data;
        end
    end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Directed bench for lbp_stream_engine: an 8x8 instance exercised with
// column-ramp, uniform and random images (with random read back-pressure),
// a mid-frame reset, and a 3x3 instance with single-window images.
module tb_lbp_stream_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 8x8 instance
    logic       start8, g8_req, g8_ready, l8_valid, fin8;
    logic [5:0] g8_addr, l8_addr;
    logic [7:0] g8_data, l8_data;
    logic [7:0] img8 [64];
    assign g8_data = img8[g8_addr];

    lbp_stream_engine #(.IMG_W(8), .IMG_H(8), .DW(8), .AW(6)) u8 (
        .clk(clk), .reset(reset), .start(start8),
        .gray_addr(g8_addr), .gray_req(g8_req), .gray_ready(g8_ready), .gray_data(g8_data),
        .lbp_addr(l8_addr), .lbp_valid(l8_valid), .lbp_data(l8_data), .finish(fin8)
    );

    // 3x3 instance
    logic       start3, g3_req, l3_valid, fin3;
    logic       g3_ready = 1'b1;
    logic [3:0] g3_addr, l3_addr;
    logic [7:0] g3_data, l3_data;
    logic [7:0] img3 [16];
    assign g3_data = img3[g3_addr];

    lbp_stream_engine #(.IMG_W(3), .IMG_H(3), .DW(8), .AW(4)) u3 (
        .clk(clk), .reset(reset), .start(start3),
        .gray_addr(g3_addr), .gray_req(g3_req), .gray_ready(g3_ready), .gray_data(g3_data),
        .lbp_addr(l3_addr), .lbp_valid(l3_valid), .lbp_data(l3_data), .finish(fin3)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc8_q [$];
    int oa8_q  [$];
    int od8_q  [$];
    int os8_q  [$];
    int oa3_q  [$];
    int od3_q  [$];
    int acc18_cyc = -1;
    int fin8_cyc  = -1;

    // Observe handshakes and strobes away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (g8_req && g8_ready) begin
                acc8_q.push_back(int'(g8_addr));
                if (g8_addr == 6'd18) acc18_cyc = cyc;
            end
            if (l8_valid) begin
                oa8_q.push_back(int'(l8_addr));
                od8_q.push_back(int'(l8_data));
                os8_q.push_back(cyc);
            end
            if (fin8 && fin8_cyc < 0) fin8_cyc = cyc;
            if (l3_valid) begin
                oa3_q.push_back(int'(l3_addr));
                od3_q.push_back(int'(l3_data));
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference LBP code for interior address a of the 8x8 image
    function automatic int golden8(input int a);
        int r, c, code;
        int dr [8];
        int dc [8];
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        r = a / 8;
        c = a % 8;
        code = 0;
        for (int k = 0; k < 8; k++)
            if (img8[(r + dr[k]) * 8 + c + dc[k]] >= img8[a]) code |= (1 << k);
        return code;
    endfunction

    task automatic fill8(input int mode);
        for (int i = 0; i < 64; i++)
            img8[i] = (mode == 0) ? 8'(i % 8) : (mode == 1) ? 8'h55 : 8'($urandom_range(0, 255));
    endtask

    task automatic start_frame8();
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        acc8_q.delete(); oa8_q.delete(); od8_q.delete(); os8_q.delete();
        acc18_cyc = -1;
        fin8_cyc  = -1;
    endtask

    // mode 0: pixel=col, 1: uniform 0x55, 2: random; rnd: 30% ready; poke: start mid-frame
    task automatic run8(input int mode, input bit rnd, input bit poke);
        bit done;
        int exp_a, exp_d;
        fill8(mode);
        start_frame8();
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            g8_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            start8   = poke && (n == 25);
            @(posedge clk); #1;
            done = fin8;
        end
        start8 = 1'b0;
        chk("finish_reached", int'(fin8), 1);
        @(negedge clk); #1;
        chk("gray_req_low_after_frame", int'(g8_req), 0);
        chk("accept_count", acc8_q.size(), 64);
        for (int i = 0; i < acc8_q.size() && i < 64; i++) chk("accept_order", acc8_q[i], i);
        chk("strobe_count", oa8_q.size(), 36);
        for (int i = 0; i < oa8_q.size() && i < 36; i++) begin
            exp_a = (i / 6 + 1) * 8 + (i % 6) + 1;
            exp_d = (mode == 0) ? 'hD6 : (mode == 1) ? 'hFF : golden8(exp_a);
            chk("strobe_addr", oa8_q[i], exp_a);
            chk("strobe_data", od8_q[i], exp_d);
        end
        if (mode == 0 && os8_q.size() > 0) begin
            chk("first_strobe_addr", oa8_q[0], 9);
            chk("first_strobe_latency", os8_q[0], acc18_cyc + 1);
            chk("finish_after_last_strobe", fin8_cyc, os8_q[os8_q.size() - 1] + 1);
        end
    endtask

    task automatic run3(input logic [7:0] centre, input logic [7:0] rest, input int exp_d);
        bit done;
        for (int i = 0; i < 16; i++) img3[i] = rest;
        img3[4] = centre;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        oa3_q.delete(); od3_q.delete();
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk); #1;
            done = fin3;
        end
        chk("finish3_reached", int'(fin3), 1);
        @(negedge clk); #1;
        chk("strobe3_count", oa3_q.size(), 1);
        if (oa3_q.size() > 0) begin
            chk("strobe3_addr", oa3_q[0], 4);
            chk("strobe3_data", od3_q[0], exp_d);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gray_req"},  int'(g8_req),   0);
        chk({tag, "_lbp_valid"}, int'(l8_valid), 0);
        chk({tag, "_finish"},    int'(fin8),     0);
        chk({tag, "_gray_addr"}, int'(g8_addr),  0);
        chk({tag, "_lbp_addr"},  int'(l8_addr),  0);
        chk({tag, "_lbp_data"},  int'(l8_data),  0);
    endtask

    initial begin
        bit hit;
        reset    = 1'b1;
        start8   = 1'b0;
        start3   = 1'b0;
        g8_ready = 1'b0;
        for (int i = 0; i < 64; i++) img8[i] = 8'h00;
        for (int i = 0; i < 16; i++) img3[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_finish3", int'(fin3), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Column ramp: every window codes 0xD6
        run8(0, 1'b0, 1'b0);
        // Uniform image under back-pressure: every neighbour >= centre
        run8(1, 1'b1, 1'b0);
        // Random image, back-pressure, ignored start pulse mid-frame
        run8(2, 1'b1, 1'b1);

        // Reset after 20 accepts of a random frame, then a clean frame
        fill8(2);
        g8_ready = 1'b1;
        start_frame8();
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge clk); #1;
            hit = (acc8_q.size() >= 20);
        end
        chk("midframe_reached", int'(hit), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset_req", int'(g8_req), 0);
        run8(2, 1'b1, 1'b0);

        // 3x3 single-window images
        run3(8'hFF, 8'h00, 'h00);
        run3(8'h00, 8'h01, 'hFF);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
